dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the cpu3 pipeline: services load/store requests issued by the MEM stage (the initiator) and returns read data or a write acknowledge.
- Replaces the behavioural data-memory model used in benches with synthesizable RTL.
- Adds programmable wait states, byte-enabled stores and address-error detection so the pipeline stall path gets exercised.

Parameters:
- BITS, 32, data and address width.
- MEM_DEPTH, 256, number of BITS-wide words; must be a power of two.
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request valid from MEM stage.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  BITS  byte address; sampled with req.
- wdata  input  BITS  store data; sampled with req.
- be  input  BITS/8  byte enables for stores, bit i selects byte lane i; ignored for loads.
- busy  output  1  request accepted and not yet acknowledged; the pipeline uses this as its stall.
- ack  output  1  one-cycle response strobe.
- rdata  output  BITS  load data; valid only while ack=1.
- err  output  1  address error flag; valid only while ack=1.

Behaviour:
- Reset: busy=0, ack=0, rdata=0, err=0.
  - FSM goes to IDLE and the wait counter clears.
  - Memory array contents are not altered by reset. The array initialises to all-zero at time 0.
  - Reset asserted mid-transaction aborts it. A pending store is discarded and no ack is produced.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req=1, latch we, addr, wdata and be. Load the counter with WAIT_STATES. Set busy=1 next cycle.
    - If WAIT_STATES=0, go to RESP; otherwise go to WAIT.
  - WAIT: decrement the counter each cycle. Go to RESP when it would reach 0.
  - RESP: ack=1 for exactly one cycle, then busy=0, then return to IDLE.
- Latency: a req sampled at edge N gives ack high in the cycle after edge N+WAIT_STATES+1.
  - busy is high from edge N+1 through the ack cycle inclusive.
- Back-to-back: req is ignored while busy=1.
  - The earliest next acceptance is the first IDLE cycle after ack; no request is taken in the RESP cycle itself.
  - Minimum cadence is WAIT_STATES+3 cycles per transaction.
- Word index = latched addr[log2(MEM_DEPTH)+1:2].
- err=1 at ack if addr[1:0]!=0 (misaligned) or addr>>2 >= MEM_DEPTH (out of range).
  - On err: no memory write, and rdata=0.
- Store: at the RESP edge, each byte lane with be[i]=1 is written from wdata; the other lanes keep their value. rdata=0 during a store ack.
  - be=0 completes normally with ack and no change to memory.
- Load: rdata = full word at the index, read in the RESP cycle. Reflects all stores acknowledged earlier.
- Outputs are registered; there is no combinational path from req or addr to ack, busy or rdata.
- Counter width is 4 bits. WAIT_STATES>15 is illegal: flag with an elaboration-time assertion.

Test Plan:
- WAIT_STATES=1; store 0x00000008 to addr 0x4 with be=0xF; then load 0x4.
  - Each ack arrives 3 cycles after its req, with busy high for 3 cycles.
  - The load returns rdata=0x00000008, err=0.
- Word at 0x10 holds 0xAABBCCDD; store 0x11223344 with be=0x5; load 0x10.
  - rdata=0xAA22CC44.
- Load from addr 0x6 (misaligned), and load from addr 0x400 with MEM_DEPTH=256.
  - Both give ack with err=1 and rdata=0.
- Store to 0x402: err=1.
  - A subsequent sweep shows all 256 words unchanged.
- WAIT_STATES=0; hold req=1 continuously, alternating store/load to 0x8.
  - Acks every 3rd cycle; each load returns the preceding store's data.
  - Requests presented while busy are not accepted.
- WAIT_STATES=3; issue a store to 0x20, assert rst in the second WAIT cycle, release.
  - No ack. busy=0 the cycle after the reset edge.
  - A later load of 0x20 returns the old value 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the cpu3 MEM stage: byte-enabled stores, loads,
// programmable wait states and address-error reporting behind a busy/ack handshake.
module dmem_responder #(
    parameter int BITS        = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [BITS-1:0]   addr,
    input  logic [BITS-1:0]   wdata,
    input  logic [BITS/8-1:0] be,
    output logic              busy,
    output logic              ack,
    output logic [BITS-1:0]   rdata,
    output logic              err
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NB = BITS / 8;

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("dmem_responder: WAIT_STATES must be in 0..15");
        end
        if ((1 << AW) != MEM_DEPTH) begin : g_bad_depth
            $error("dmem_responder: MEM_DEPTH must be a power of two");
        end
    endgenerate

    // Handshake: a request is taken at a rising edge where req=1 and busy=0 in IDLE.
    // busy stays high until the end of the single ack cycle; req is ignored meanwhile.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [BITS-1:0]     r_addr;
    logic [BITS-1:0]     r_wdata;
    logic [NB-1:0]       r_be;
    logic                r_busy;
    logic                r_ack;
    logic                r_err;
    logic [BITS-1:0]     r_rdata;
    logic [BITS-1:0]     r_mem [MEM_DEPTH] = '{default: '0};

    logic                w_accept;
    logic                w_busy_d;
    logic                w_addr_err;
    logic [AW-1:0]       w_idx;

    assign w_idx      = r_addr[AW+1:2];
    assign w_addr_err = (r_addr[1:0] != 2'b00) || ((r_addr >> 2) >= BITS'(MEM_DEPTH));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req && !r_busy) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // RESP is the access cycle; the registered ack lands in the following IDLE cycle.
        w_busy_d = (w_next != S_IDLE) || (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_d;
            r_ack   <= (r_state == S_RESP);
            if (w_accept) begin
                r_cnt <= 4'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_RESP) begin
                r_err   <= w_addr_err;
                r_rdata <= (r_we || w_addr_err) ? '0 : r_mem[w_idx];
            end else begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
        end
    end

    // A reset landing on the access edge must still discard the store.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_RESP && r_we && !w_addr_err) begin
            for (int i = 0; i < NB; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign busy  = r_busy;
    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3) driven by directed
// and random transactions, checked against a word-array model and an expected-data queue.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_v   [3];
    logic        we_v    [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [3:0]  be_v    [3];
    logic        busy_v  [3];
    logic        ack_v   [3];
    logic [31:0] rdata_v [3];
    logic        err_v   [3];

    logic [31:0] model_mem [3][256];
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_err;

    dmem_responder #(.BITS(32), .MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .be(be_v[0]), .busy(busy_v[0]), .ack(ack_v[0]),
        .rdata(rdata_v[0]), .err(err_v[0])
    );
    dmem_responder #(.BITS(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .be(be_v[1]), .busy(busy_v[1]), .ack(ack_v[1]),
        .rdata(rdata_v[1]), .err(err_v[1])
    );
    dmem_responder #(.BITS(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .be(be_v[2]), .busy(busy_v[2]), .ack(ack_v[2]),
        .rdata(rdata_v[2]), .err(err_v[2])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    // Called at a negedge with instance d idle. Request is taken at the next posedge (edge N);
    // the bench then samples on negedges after edges N..N+ws+2.
    task automatic run_txn(input int d, input logic t_we, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, input logic [3:0] t_be, input bit keep,
                           output logic [31:0] got_rdata, output logic got_err);
        int          ws;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        ws = ws_of(d);
        req_v[d]   = 1'b1;
        we_v[d]    = t_we;
        addr_v[d]  = t_addr;
        wdata_v[d] = t_wdata;
        be_v[d]    = t_be;
        exp_err = (t_addr % 4 != 0) || (t_addr / 4 >= 256);
        idx     = int'(t_addr[9:2]);
        if (t_we && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (t_be[b]) model_mem[d][idx][8*b +: 8] = t_wdata[8*b +: 8];
            end
        end
        exp_rd = (t_we || exp_err) ? 32'h0 : model_mem[d][idx];
        exp_q.push_back(exp_rd);
        got_rdata = 32'h0;
        got_err   = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= ws + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (keep) begin
                    // a store presented while busy must be ignored
                    we_v[d]    = 1'b1;
                    wdata_v[d] = $urandom;
                    be_v[d]    = 4'hF;
                end else begin
                    req_v[d] = 1'b0;
                end
            end
            check("busy", 32'(busy_v[d]), 32'(k <= ws + 1));
            check("ack", 32'(ack_v[d]), 32'(k == ws + 1));
            if (k == ws + 1) begin
                got_rdata = rdata_v[d];
                got_err   = err_v[d];
                check("rdata", rdata_v[d], exp_q.pop_front());
                check("err", 32'(err_v[d]), 32'(exp_err));
            end
        end
    endtask

    logic [31:0] got;
    logic        gerr;
    logic [31:0] last_store;
    logic [31:0] ra;

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0; be_v[d] = '0;
            for (int w = 0; w < 256; w++) model_mem[d][w] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("rst_busy", 32'(busy_v[d]), 32'h0);
            check("rst_ack", 32'(ack_v[d]), 32'h0);
            check("rst_rdata", rdata_v[d], 32'h0);
            check("rst_err", 32'(err_v[d]), 32'h0);
        end

        // full-word store then load
        run_txn(0, 1'b1, 32'h4, 32'h0000_0008, 4'hF, 1'b0, got, gerr);
        run_txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, got, gerr);
        check("load_0x4", got, 32'h0000_0008);

        // partial byte-lane store
        run_txn(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'hF, 1'b0, got, gerr);
        run_txn(0, 1'b1, 32'h10, 32'h1122_3344, 4'h5, 1'b0, got, gerr);
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got, gerr);
        check("be_merge", got, 32'hAA22_CC44);
        run_txn(0, 1'b1, 32'h14, 32'h5555_5555, 4'h0, 1'b0, got, gerr);

        // address errors
        run_txn(0, 1'b0, 32'h6, 32'h0, 4'h0, 1'b0, got, gerr);
        check("misalign_err", 32'(gerr), 32'h1);
        run_txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, got, gerr);
        check("oob_err", 32'(gerr), 32'h1);
        check("oob_rdata", got, 32'h0);
        run_txn(0, 1'b1, 32'h402, 32'hFFFF_FFFF, 4'hF, 1'b0, got, gerr);
        check("oob_store_err", 32'(gerr), 32'h1);
        for (int w = 0; w < 256; w++) begin
            run_txn(0, 1'b0, 32'(w * 4), 32'h0, 4'h0, 1'b0, got, gerr);
        end

        // zero wait states, req held high, alternating store/load to 0x8
        last_store = 32'h0;
        for (int t = 0; t < 8; t++) begin
            if (t % 2 == 0) begin
                last_store = $urandom;
                run_txn(1, 1'b1, 32'h8, last_store, 4'hF, 1'b1, got, gerr);
            end else begin
                run_txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, got, gerr);
                check("b2b_load", got, last_store);
            end
        end
        req_v[1] = 1'b0;
        run_txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, got, gerr);
        check("b2b_final", got, last_store);

        // reset during the second wait cycle aborts a store
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 32'h20; wdata_v[2] = 32'hDEAD_BEEF;
        be_v[2] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_v[2] = 1'b0;
        check("abort_busy_pre", 32'(busy_v[2]), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy_v[2]), 32'h0);
        check("abort_ack", 32'(ack_v[2]), 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_ack", 32'(ack_v[2]), 32'h0);
        end
        run_txn(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, got, gerr);
        check("abort_old_value", got, 32'h0);

        // random traffic on every instance
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 40; t++) begin
                case ($urandom_range(0, 9))
                    7:       ra = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
                    8:       ra = 32'($urandom_range(256, 4000)) << 2;
                    9:       ra = $urandom;
                    default: ra = {22'h0, 4'h0, 4'($urandom_range(0, 15)), 2'b00};
                endcase
                run_txn(d, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
                        1'b0, got, gerr);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
